bcd_digit_multiplier: RTL and testbench



---
 rtl/bcd_digit_multiplier_if.sv | 16 +
 rtl/bcd_digit_multiplier.sv | 122 ++++++++++++
 tb/tb_bcd_digit_multiplier.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_multiplier_if.sv
// Start/done handshake bundle for the BCD digit multiplier.
// The master drives the operands and start; the slave returns status and the product.
interface bcd_digit_multiplier_if #(
    parameter int DIGITS = 3
);
    logic                    start;
    logic [4*DIGITS-1:0]     a;
    logic [3:0]              m;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [4*(DIGITS+1)-1:0] q;

    modport master (output start, a, m, input busy, done, err, q);
    modport slave  (input start, a, m, output busy, done, err, q);
endinterface

// File: rtl/bcd_digit_multiplier.sv
// Packed-BCD multiplicand times one BCD digit, one digit per clock,
// least-significant digit first, with a decimal carry chain.
module bcd_digit_multiplier #(
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_digit_multiplier_if.slave bus
);
    localparam int AW    = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       carry_q, carry_d;
    logic             err_q, err_d;
    logic [AW+3:0]    q_q, q_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [3:0]       m_q, m_d;
    logic [3:0]       cur_digit;
    logic [6:0]       prod;

    function automatic logic operands_ok(input logic [AW-1:0] av, input logic [3:0] mv);
        logic ok;
        ok = (mv <= 4'd9);
        for (int i = 0; i < DIGITS; i++) begin
            if (av[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Digit product plus incoming carry never exceeds 9*9+8 = 89.
    function automatic logic [6:0] mac_digit(input logic [3:0] d, input logic [3:0] mv,
                                             input logic [3:0] c);
        return 7'(d) * 7'(mv) + 7'(c);
    endfunction

    function automatic logic [3:0] dec_lo(input logic [6:0] p);
        return 4'(p % 7'd10);
    endfunction

    function automatic logic [3:0] dec_hi(input logic [6:0] p);
        return 4'(p / 7'd10);
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        err_d     = err_q;
        q_d       = q_q;
        a_d       = a_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cur_digit = a_q[4*int'(idx_q) +: 4];
        prod      = mac_digit(cur_digit, m_q, carry_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    m_d     = bus.m;
                    idx_d   = '0;
                    carry_d = '0;
                    err_d   = 1'b0;
                    if (!operands_ok(bus.a, bus.m)) begin
                        err_d   = 1'b1;
                        q_d     = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d[4*int'(idx_q) +: 4] = dec_lo(prod);
                carry_d                   = dec_hi(prod);
                if (idx_q == LAST_IDX) begin
                    // acc_d already holds the digit produced this cycle.
                    q_d     = {dec_hi(prod), acc_d};
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= '0;
            err_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            q_q     <= q_d;
        end
    end

    // Operand and scratch registers are only read in RUN, so they need no reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        m_q   <= m_d;
        acc_q <= acc_d;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.err  = err_q;
    assign bus.q    = q_q;
endmodule

// File: tb/tb_bcd_digit_multiplier.sv
// Scoreboard bench for bcd_digit_multiplier at DIGITS = 3, 1 and 6.
module tb_bcd_digit_multiplier;
    typedef struct {
        logic [27:0] q;
        logic        err;
        int          t;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb3[$];
    exp_t sb1[$];
    exp_t sb6[$];

    bcd_digit_multiplier_if #(.DIGITS(3)) b3 ();
    bcd_digit_multiplier_if #(.DIGITS(1)) b1 ();
    bcd_digit_multiplier_if #(.DIGITS(6)) b6 ();

    bcd_digit_multiplier #(.DIGITS(3)) dut3 (.clk(clk), .reset(rst), .bus(b3));
    bcd_digit_multiplier #(.DIGITS(1)) dut1 (.clk(clk), .reset(rst), .bus(b1));
    bcd_digit_multiplier #(.DIGITS(6)) dut6 (.clk(clk), .reset(rst), .bus(b6));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint int2bcd(input longint x, input int n);
        longint r = 0;
        for (int i = 0; i < n; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Monitors: pop one expectation per done pulse, and require q to hold otherwise.
    initial begin
        logic [15:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) prev = b3.q;
            else begin
                if (b3.done) begin
                    chk("d3_done_pending", longint'(sb3.size() > 0), 1);
                    if (sb3.size() > 0) begin
                        e = sb3.pop_front();
                        chk("d3_q", b3.q, e.q);
                        chk("d3_err", b3.err, e.err);
                        chk("d3_latency", cyc - e.t, e.lat);
                    end
                end else chk("d3_q_stable", b3.q, prev);
                prev = b3.q;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && b1.done) begin
                chk("d1_done_pending", longint'(sb1.size() > 0), 1);
                if (sb1.size() > 0) begin
                    e = sb1.pop_front();
                    chk("d1_q", b1.q, e.q);
                    chk("d1_err", b1.err, e.err);
                    chk("d1_latency", cyc - e.t, e.lat);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && b6.done) begin
                chk("d6_done_pending", longint'(sb6.size() > 0), 1);
                if (sb6.size() > 0) begin
                    e = sb6.pop_front();
                    chk("d6_q", b6.q, e.q);
                    chk("d6_err", b6.err, e.err);
                    chk("d6_latency", cyc - e.t, e.lat);
                end
            end
        end
    end

    task automatic wait_idle3(output int busy_cnt);
        busy_cnt = 0;
        for (int k = 0; k < 20 && b3.busy; k++) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("d3_back_to_idle", b3.busy, 0);
    endtask

    task automatic issue3(input logic [11:0] a, input logic [3:0] m, input logic [15:0] q_exp,
                          input logic e_exp, output int busy_cnt);
        exp_t e;
        @(negedge clk);
        b3.start = 1'b1; b3.a = a; b3.m = m;
        e.q = 28'(q_exp); e.err = e_exp; e.t = cyc + 1; e.lat = e_exp ? 0 : 3;
        sb3.push_back(e);
        @(negedge clk);
        b3.start = 1'b0;
        wait_idle3(busy_cnt);
    endtask

    task automatic issue1(input logic [3:0] a, input logic [3:0] m, input logic [7:0] q_exp,
                          input logic e_exp);
        exp_t e;
        @(negedge clk);
        b1.start = 1'b1; b1.a = a; b1.m = m;
        e.q = 28'(q_exp); e.err = e_exp; e.t = cyc + 1; e.lat = e_exp ? 0 : 1;
        sb1.push_back(e);
        @(negedge clk);
        b1.start = 1'b0;
        for (int k = 0; k < 20 && b1.busy; k++) @(negedge clk);
        chk("d1_back_to_idle", b1.busy, 0);
    endtask

    task automatic issue6(input logic [23:0] a, input logic [3:0] m, input logic [27:0] q_exp,
                          input logic e_exp);
        exp_t e;
        @(negedge clk);
        b6.start = 1'b1; b6.a = a; b6.m = m;
        e.q = q_exp; e.err = e_exp; e.t = cyc + 1; e.lat = e_exp ? 0 : 6;
        sb6.push_back(e);
        @(negedge clk);
        b6.start = 1'b0;
        for (int k = 0; k < 30 && b6.busy; k++) @(negedge clk);
        chk("d6_back_to_idle", b6.busy, 0);
    endtask

    initial begin
        int     bc;
        exp_t   e;
        longint av, qv;
        b3.start = 1'b0; b3.a = '0; b3.m = '0;
        b1.start = 1'b0; b1.a = '0; b1.m = '0;
        b6.start = 1'b0; b6.a = '0; b6.m = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", b3.busy, 0);
        chk("rst_done", b3.done, 0);
        chk("rst_err", b3.err, 0);
        chk("rst_q", b3.q, 0);
        chk("rst_d6_q", b6.q, 0);

        issue3(12'h499, 4'd2, 16'h0998, 1'b0, bc);
        chk("d3_busy_cycles", bc, 4);
        issue3(12'h999, 4'd9, 16'h8991, 1'b0, bc);
        issue3(12'h123, 4'd0, 16'h0000, 1'b0, bc);
        issue3(12'h507, 4'd1, 16'h0507, 1'b0, bc);
        issue3(12'h1A3, 4'd3, 16'h0000, 1'b1, bc);
        chk("d3_err_busy_cycles", bc, 1);
        issue3(12'h100, 4'hC, 16'h0000, 1'b1, bc);
        chk("d3_err_held", b3.err, 1);

        // A fresh valid start must clear err on its accepting edge.
        @(negedge clk);
        b3.start = 1'b1; b3.a = 12'h123; b3.m = 4'd1;
        e.q = 28'h0123; e.err = 1'b0; e.t = cyc + 1; e.lat = 3;
        sb3.push_back(e);
        @(negedge clk);
        b3.start = 1'b0;
        chk("d3_err_cleared", b3.err, 0);
        wait_idle3(bc);

        // Second start and operand changes during RUN are ignored.
        @(negedge clk);
        b3.start = 1'b1; b3.a = 12'h499; b3.m = 4'd2;
        e.q = 28'h0998; e.err = 1'b0; e.t = cyc + 1; e.lat = 3;
        sb3.push_back(e);
        @(negedge clk);
        b3.a = 12'h999; b3.m = 4'd9;
        @(negedge clk);
        b3.start = 1'b0;
        wait_idle3(bc);

        // Asynchronous reset mid-RUN: outputs clear immediately, no done pulse follows.
        @(negedge clk);
        b3.start = 1'b1; b3.a = 12'h999; b3.m = 4'd9;
        @(negedge clk);
        b3.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_busy", b3.busy, 0);
        chk("amid_done", b3.done, 0);
        chk("amid_err", b3.err, 0);
        chk("amid_q", b3.q, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("amid_still_idle", b3.busy, 0);

        // Held start: restarts with a DIGITS+2 cycle period.
        @(negedge clk);
        b3.start = 1'b1; b3.a = 12'h250; b3.m = 4'd4;
        e.q = 28'h1000; e.err = 1'b0; e.t = cyc + 1; e.lat = 3;
        sb3.push_back(e);
        e.t = cyc + 1 + 5;
        sb3.push_back(e);
        repeat (6) @(negedge clk);
        b3.start = 1'b0;
        wait_idle3(bc);

        for (int ai = 0; ai < 1000; ai++) begin
            for (int mi = 0; mi < 10; mi++) begin
                av = int2bcd(longint'(ai), 3);
                qv = int2bcd(longint'(ai * mi), 4);
                issue3(av[11:0], 4'(mi), qv[15:0], 1'b0, bc);
            end
        end

        issue1(4'h9, 4'd9, 8'h81, 1'b0);
        issue1(4'hA, 4'd1, 8'h00, 1'b1);
        for (int ai = 0; ai < 10; ai++) begin
            for (int mi = 0; mi < 10; mi++) begin
                qv = int2bcd(longint'(ai * mi), 2);
                issue1(4'(ai), 4'(mi), qv[7:0], 1'b0);
            end
        end

        issue6(24'h999999, 4'd9, 28'h8999991, 1'b0);
        issue6(24'h123456, 4'd7, 28'h0864192, 1'b0);
        issue6(24'h999999, 4'd1, 28'h0999999, 1'b0);
        issue6(24'h000001, 4'hF, 28'h0000000, 1'b1);
        issue6(24'h0F0000, 4'd2, 28'h0000000, 1'b1);

        for (int k = 0; k < 20 && (sb3.size() + sb1.size() + sb6.size()) != 0; k++)
            @(negedge clk);
        chk("scoreboard_drained", sb3.size() + sb1.size() + sb6.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
